// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - rx_state_t      : receiver FSM states (PARITY only reachable when the
//                       UART_RX_PARITY_EN build option is defined)
//   - DEF_*           : default frame / oversampling constants
//   - even_parity()   : parity bit that makes the popcount of (data, bit) even
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DEF_DBIT       = 8;
    localparam int DEF_SB_TICK    = 16;
    localparam int DEF_OVERSAMPLE = 16;

    // Zero-extension does not change parity, so one 32-bit helper serves any
    // data width up to 32.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO, depth 2**AW.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, wdata     : write request and data; dropped when full unless a pop
//                     happens in the same cycle
//   pop             : remove head entry; ignored when empty
//   rdata           : head entry, forced to 0 while empty
//   empty, full     : occupancy flags decoded from the registered pointers
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem [2**AW];
    // Extra MSB on each pointer separates the full case from the empty case.
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          wr_en;
    logic          rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign rd_en = pop && !empty;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);

    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + (AW+1)'(1);
            if (rd_en) rptr <= rptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately left out of reset; validity is tracked by
    // the pointers alone, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Oversampling 8N1 UART receiver feeding a FWFT byte FIFO for the debug unit.
// Build option: define UART_RX_PARITY_EN to receive 8E1 frames (even parity)
// and expose o_parity_err.
// Ports:
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_baud_tick     : one-cycle strobe at OVERSAMPLE x baud
//   i_uart_rx       : asynchronous serial line, idles high
//   i_rd            : pop FIFO head (ignored when empty)
//   o_rx_data       : FIFO head byte, valid while o_rx_empty = 0
//   o_rx_empty/full : FIFO flags
//   o_rx_done_tick  : pulse, good frame stored
//   o_frame_err     : pulse, stop bit sampled low (byte discarded)
//   o_overrun       : pulse, good frame dropped because the FIFO was full
//   o_parity_err    : pulse, parity mismatch (only with UART_RX_PARITY_EN)
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT       = DEF_DBIT,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int FIFO_AW    = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_baud_tick,
    input  logic            i_uart_rx,
    input  logic            i_rd,
    output logic [DBIT-1:0] o_rx_data,
    output logic            o_rx_empty,
    output logic            o_rx_full,
    output logic            o_rx_done_tick,
    output logic            o_frame_err,
    output logic            o_overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic            o_parity_err
`endif
);

    localparam int CNT_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int NW      = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [CW-1:0] MID_TICK  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_TICK  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] STOP_TICK = CW'(SB_TICK - 1);
    localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);

    logic [1:0]      sync;
    logic            rx;
    rx_state_t       state;
    logic [CW-1:0]   s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] shreg;
    logic            stop_sample;
    logic            push;
    logic            fifo_full;
`ifdef UART_RX_PARITY_EN
    logic            par_bad;
`endif

    // NOTE: two flops before any decision; the line is asynchronous to i_clk.
    // Reset to 1 so a reset release never looks like a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync <= 2'b11;
        else       sync <= {sync[0], i_uart_rx};
    end

    assign rx = sync[1];

    assign stop_sample = (state == STOP) && i_baud_tick && (s_cnt == STOP_TICK);
`ifdef UART_RX_PARITY_EN
    assign push = stop_sample && rx && !par_bad;
`else
    assign push = stop_sample && rx;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            s_cnt          <= '0;
            n_cnt          <= '0;
            shreg          <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
            o_overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad        <= 1'b0;
            o_parity_err   <= 1'b0;
`endif
        end else begin
            // NOTE: pulses are registered from the same pre-edge values that
            // drive the FIFO write, so they line up with the new FIFO state.
            o_rx_done_tick <= push && (!fifo_full || i_rd);
            o_overrun      <= push && fifo_full && !i_rd;
            o_frame_err    <= stop_sample && !rx;
`ifdef UART_RX_PARITY_EN
            o_parity_err   <= stop_sample && rx && par_bad;
`endif
            unique case (state)
                IDLE: begin
                    if (!rx) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (i_baud_tick) begin
                        if (s_cnt == MID_TICK) begin
                            if (!rx) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;  // short low pulse: not a start bit
                            end
                        end else begin
                            s_cnt <= s_cnt + CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_baud_tick) begin
                        if (s_cnt == BIT_TICK) begin
                            s_cnt <= '0;
                            // LSB arrives first, so shifting right leaves it at bit 0.
                            shreg <= {rx, shreg[DBIT-1:1]};
                            if (n_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n_cnt <= n_cnt + NW'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + CW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_baud_tick) begin
                        if (s_cnt == BIT_TICK) begin
                            s_cnt   <= '0;
                            par_bad <= (even_parity(32'(shreg)) != rx);
                            state   <= STOP;
                        end else begin
                            s_cnt <= s_cnt + CW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_baud_tick) begin
                        if (s_cnt == STOP_TICK) state <= IDLE;
                        else                    s_cnt <= s_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .DW (DBIT),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (i_rd),
        .wdata (shreg),
        .rdata (o_rx_data),
        .empty (o_rx_empty),
        .full  (fifo_full)
    );

    assign o_rx_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo: a table of single frames with expected
// pulse counts and FIFO head/empty values, followed by hand-written sequences
// for glitch rejection, overrun, push+pop while full and reset mid-frame.
// Baud tick = every second clock, 16 ticks per bit => 32 clocks per bit.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       i_clk       = 1'b0;
    logic       i_rst       = 1'b1;
    logic       i_baud_tick = 1'b0;
    logic       i_uart_rx   = 1'b1;
    logic       i_rd        = 1'b0;
    logic [7:0] o_rx_data;
    logic       o_rx_empty;
    logic       o_rx_full;
    logic       o_rx_done_tick;
    logic       o_frame_err;
    logic       o_overrun;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int perr_cnt = 0;

    uart_rx_fifo #(
        .DBIT       (8),
        .SB_TICK    (16),
        .OVERSAMPLE (16),
        .FIFO_AW    (4)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_baud_tick    (i_baud_tick),
        .i_uart_rx      (i_uart_rx),
        .i_rd           (i_rd),
        .o_rx_data      (o_rx_data),
        .o_rx_empty     (o_rx_empty),
        .o_rx_full      (o_rx_full),
        .o_rx_done_tick (o_rx_done_tick),
        .o_frame_err    (o_frame_err),
        .o_overrun      (o_overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_err   (o_parity_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial forever @(negedge i_clk) i_baud_tick = ~i_baud_tick;

    // Pulse counters, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (o_rx_done_tick) done_cnt++;
        if (o_frame_err)    ferr_cnt++;
        if (o_overrun)      ovr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (o_parity_err)   perr_cnt++;
`endif
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic align_tick();
        do @(posedge i_clk); while (!i_baud_tick);
        @(negedge i_clk);
    endtask

    task automatic send_bit(input logic b, input int ticks);
        i_uart_rx = b;
        repeat (2 * ticks) @(negedge i_clk);
    endtask

    // Start bit, 8 data bits LSB first, optional parity, stop bit, 2 idle bits.
    // A bad stop bit is held 12 ticks so the FSM's immediate re-entry into
    // START sees the line high at mid-bit. With rd_at_stop, i_rd is high for
    // exactly the clock edge on which the stop bit is sampled (17.5 clocks
    // into the stop bit).
    task automatic send_frame(input logic [7:0] data, input logic stop_ok,
                              input logic rd_at_stop, input logic par_flip);
        align_tick();
        send_bit(1'b0, 16);
        for (int k = 0; k < 8; k++) send_bit(data[k], 16);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ par_flip, 16);
`endif
        i_uart_rx = stop_ok;
        repeat (17) @(negedge i_clk);
        if (rd_at_stop) i_rd = 1'b1;
        @(negedge i_clk);
        i_rd = 1'b0;
        repeat (stop_ok ? 14 : 6) @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (64) @(negedge i_clk);
    endtask

    task automatic pop();
        @(negedge i_clk);
        i_rd = 1'b1;
        @(negedge i_clk);
        i_rd = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       do_pop;
        int         exp_done;
        int         exp_ferr;
        logic       exp_empty;
        logic [7:0] exp_head;
        logic       exp_empty_after;
        logic [7:0] exp_head_after;
    } vec_t;

    vec_t vecs[7];

    int d0, f0, o0, p0;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 1, 0, 1'b0, 8'h55, 1'b1, 8'h00};
        vecs[1] = '{8'hA3, 1'b0, 1'b1, 0, 1, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1, 0, 1'b0, 8'h3C, 1'b1, 8'h00};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1, 0, 1'b0, 8'h01, 1'b0, 8'h01};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1, 0, 1'b0, 8'h01, 1'b0, 8'h80};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1, 0, 1'b0, 8'h80, 1'b0, 8'hFF};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 0, 1, 1'b0, 8'hFF, 1'b1, 8'h00};

        // Reset state, both while held and after release.
        repeat (3) @(negedge i_clk);
        check("rst empty", 32'(o_rx_empty), 32'h1);
        check("rst full",  32'(o_rx_full),  32'h0);
        check("rst data",  32'(o_rx_data),  32'h0);
        check("rst pulses", 32'({o_rx_done_tick, o_frame_err, o_overrun}), 32'h0);
        i_rst = 1'b0;
        repeat (8) @(negedge i_clk);
        check("post-rst empty", 32'(o_rx_empty), 32'h1);
        check("post-rst pulse count", 32'(done_cnt + ferr_cnt + ovr_cnt), 32'h0);

        // Table of single frames.
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt; f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_ok, 1'b0, 1'b0);
            check($sformatf("v%0d done", i),  32'(done_cnt - d0), 32'(vecs[i].exp_done));
            check($sformatf("v%0d ferr", i),  32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d empty", i), 32'(o_rx_empty), 32'(vecs[i].exp_empty));
            check($sformatf("v%0d head", i),  32'(o_rx_data),  32'(vecs[i].exp_head));
            if (vecs[i].do_pop) pop();
            check($sformatf("v%0d empty after", i), 32'(o_rx_empty), 32'(vecs[i].exp_empty_after));
            check($sformatf("v%0d head after", i),  32'(o_rx_data),  32'(vecs[i].exp_head_after));
        end
        check("table overrun count", 32'(ovr_cnt), 32'h0);

        // Glitch: 5 ticks low, then high.
        d0 = done_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        align_tick();
        i_uart_rx = 1'b0;
        repeat (10) @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (96) @(negedge i_clk);
        check("glitch pulses", 32'((done_cnt - d0) + (ferr_cnt - f0) + (ovr_cnt - o0)), 32'h0);
        check("glitch empty", 32'(o_rx_empty), 32'h1);

        // Overrun: 17 bytes into a 16-deep FIFO with no reads.
        d0 = done_cnt; o0 = ovr_cnt;
        for (int b = 0; b < 17; b++) begin
            send_frame(8'(b), 1'b1, 1'b0, 1'b0);
            if (b == 14) check("15 entries not full", 32'(o_rx_full), 32'h0);
            if (b == 15) check("16 entries full", 32'(o_rx_full), 32'h1);
        end
        check("overrun done count", 32'(done_cnt - d0), 32'd16);
        check("overrun pulse count", 32'(ovr_cnt - o0), 32'd1);
        check("overrun still full", 32'(o_rx_full), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("overrun read %0d", i), 32'(o_rx_data), 32'(i));
            pop();
        end
        check("overrun drained empty", 32'(o_rx_empty), 32'h1);
        pop();
        check("pop while empty ignored", 32'(o_rx_empty), 32'h1);

        // Push and pop on the same edge while full.
        for (int b = 0; b < 16; b++) send_frame(8'(8'h20 + b), 1'b1, 1'b0, 1'b0);
        check("simul pre full", 32'(o_rx_full), 32'h1);
        d0 = done_cnt; o0 = ovr_cnt;
        send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
        check("simul overrun", 32'(ovr_cnt - o0), 32'h0);
        check("simul done", 32'(done_cnt - d0), 32'h1);
        check("simul full", 32'(o_rx_full), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("simul read %0d", i), 32'(o_rx_data),
                  (i == 15) ? 32'h7E : 32'(8'h21 + i));
            pop();
        end
        check("simul drained empty", 32'(o_rx_empty), 32'h1);

        // Reset in the middle of data bit 4 of 0xFF, with a byte already queued.
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        check("pre-reset queued", 32'(o_rx_empty), 32'h0);
        d0 = done_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
            begin
                align_tick();
                repeat (32 * 5 + 16) @(negedge i_clk);
                i_rst = 1'b1;
                repeat (2) @(negedge i_clk);
                i_rst = 1'b0;
            end
        join
        check("reset-mid pulses", 32'((done_cnt - d0) + (ferr_cnt - f0) + (ovr_cnt - o0)), 32'h0);
        check("reset-mid empty", 32'(o_rx_empty), 32'h1);
        check("reset-mid data", 32'(o_rx_data), 32'h0);
        d0 = done_cnt;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        check("after reset done", 32'(done_cnt - d0), 32'h1);
        check("after reset head", 32'(o_rx_data), 32'h81);
        pop();
        check("after reset drained", 32'(o_rx_empty), 32'h1);

`ifdef UART_RX_PARITY_EN
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        check("parity err pulse", 32'(perr_cnt - p0), 32'h1);
        check("parity no done", 32'(done_cnt - d0), 32'h0);
        check("parity no ferr", 32'(ferr_cnt - f0), 32'h0);
        check("parity empty", 32'(o_rx_empty), 32'h1);
`else
        p0 = perr_cnt;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front-end feeding the debug unit over the board UART line.
- Oversamples `i_uart_rx` against an external baud tick and recovers 8N1 frames.
- Queues received bytes in a first-word-fall-through FIFO, which the debugger drains by reading `o_rx_data` and pulsing `i_rd`.
- Replaces ad-hoc receive logic so the debugger sees a clean empty/full/data interface.

Parameters:
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: oversample ticks spent in the stop bit (16 = 1 stop bit).
- `OVERSAMPLE`, 16: baud ticks per bit period; must be even.
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW.

Ports:
- `i_clk` in 1: system clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_baud_tick` in 1: one-`i_clk`-wide pulse at OVERSAMPLE x baud rate.
- `i_uart_rx` in 1: raw serial line; idles high.
- `i_rd` in 1: pop head entry; ignored when empty.
- `o_rx_data` out DBIT: FIFO head byte; valid when `o_rx_empty` = 0.
- `o_rx_empty` out 1: FIFO empty.
- `o_rx_full` out 1: FIFO full.
- `o_rx_done_tick` out 1: one-cycle pulse when a good frame is pushed.
- `o_frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `o_overrun` out 1: one-cycle pulse when a good frame arrives with the FIFO full.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - FSM in IDLE; all counters 0.
  - Synchronizer flops and shift register forced to 1 / 0 respectively.
  - FIFO pointers 0, `o_rx_empty` = 1, `o_rx_full` = 0.
  - `o_rx_data` = 0, all pulses 0.
- Input synchronization: 2-flop synchronizer on `i_uart_rx`, reset value 1. All FSM decisions use the synchronized bit.
- Counters advance only on cycles with `i_baud_tick` = 1.
- FSM states:
  - IDLE: synchronized rx = 0 -> START, tick count cleared.
  - START: at tick OVERSAMPLE/2-1 (mid-bit), rx still 0 -> DATA with tick and bit counts cleared; rx = 1 -> IDLE (glitch rejected, nothing pushed, no error).
  - DATA: at tick OVERSAMPLE-1, shift rx into the MSB of the shift register (LSB-first reassembly) and clear the tick count. After DBIT bits -> STOP (or PARITY when the feature is enabled).
  - STOP: at tick SB_TICK-1, rx = 1 -> push byte, pulse `o_rx_done_tick`; rx = 0 -> pulse `o_frame_err`, discard the byte. Either way -> IDLE.
- Latency:
  - Push and pulses occur the `i_clk` cycle after the stop-sample tick.
  - If the FIFO was empty, `o_rx_data` is valid and `o_rx_empty` deasserts on that same cycle.
- FIFO boundaries:
  - Push while full and no pop: byte dropped, `o_overrun` pulses, `o_rx_done_tick` is not asserted, contents unchanged.
  - Push and pop in the same cycle while full: both happen, full stays 1, no overrun.
  - Push and pop in the same cycle while empty: the byte is written, the pop is ignored, empty deasserts.
  - Pop while empty: ignored.
  - Pointers wrap modulo 2^FIFO_AW; an extra MSB distinguishes full from empty.
- Reset mid-frame: partial byte discarded, FIFO cleared. After release, reception resumes only on a fresh falling edge seen from IDLE.
- An rx that is low continuously: after a frame error the FSM returns to IDLE, then re-enters START immediately.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state follows DATA and samples one bit at tick OVERSAMPLE-1.
  - Parity is even across the data bits plus the parity bit.
  - Adds port `o_parity_err` (out 1): one-cycle pulse, byte discarded, STOP still traversed.
  - When the stop bit is also bad, only `o_frame_err` fires.
- Undefined: no PARITY state, no `o_parity_err` port; the frame is 8N1.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Default DBIT / OVERSAMPLE / SB_TICK constants.
  - The even-parity function.
- Sub-module `sync_fifo`: parameterized by data width and address width, with push/pop/empty/full, FWFT head output and registered pointers.
- Top level: the synchronizer, the FSM, and the instance of `sync_fifo`.

Test Plan:
- Single frame: send 0x55 at tick spacing 16 -> one `o_rx_done_tick`; `o_rx_data` = 0x55; empty falls; `i_rd` pulse -> empty = 1.
- Glitch: drive rx low for 5 ticks then high -> FSM returns to IDLE; no pulses; FIFO stays empty.
- Framing: send 0xA3 with stop bit held low -> `o_frame_err` pulses once; FIFO empty. Next good frame 0x3C is received correctly.
- Overrun: send 17 bytes 0x00..0x10 with no reads (FIFO_AW = 4) -> full after 16; 0x10 dropped with `o_overrun` pulse. Reads return 0x00..0x0F in order.
- Simultaneous: FIFO full, frame 0x7E completes on the same cycle `i_rd` = 1 -> no overrun; 0x7E ends up at the tail.
- Reset mid-frame: assert `i_rst` during bit 4 of 0xFF -> FIFO empty, no pulses. A following 0x81 is received intact. With `UART_RX_PARITY_EN`, 0x81 carrying a wrong parity bit -> `o_parity_err` pulses and the FIFO stays empty.
